// File: rtl/cart_rom_mapper_if.sv
// Bus bundle between the cartridge ROM mapper, the Z80 slot side and the memory arbiter.
//   cs, cpu_addr, cpu_din, cpu_rd, cpu_wr : CPU access (slot select, address, write data, strobes)
//   cpu_dout, cpu_wait                    : read data and wait request back to the CPU
//   mem_addr, mem_rd                      : read request toward the memory arbiter
//   mem_ack, mem_din                      : one-cycle acknowledge with read data
// The slave modport is the mapper; master is whatever drives the CPU and memory sides.
interface cart_rom_mapper_if;
    logic        cs;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic        cpu_wait;
    logic [24:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack;
    logic [7:0]  mem_din;

    modport slave (
        input  cs, cpu_addr, cpu_din, cpu_rd, cpu_wr, mem_ack, mem_din,
        output cpu_dout, cpu_wait, mem_addr, mem_rd
    );

    modport master (
        output cs, cpu_addr, cpu_din, cpu_rd, cpu_wr, mem_ack, mem_din,
        input  cpu_dout, cpu_wait, mem_addr, mem_rd
    );
endinterface

// File: rtl/cart_rom_mapper.sv
// Cartridge ROM mapper: turns slot-selected Z80 reads into external-memory byte addresses
// using the detected mapper type, plain-ROM offset and image size. Keeps the MegaROM bank
// registers (written by CPU writes) and runs a single-outstanding read toward memory,
// stalling the CPU with cpu_wait until the data is back.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   rom_loading  : image download in progress; banks held at defaults, reads miss
//   mapper       : 0 unknown, 1 plain, 2 GameMaster2, 3 Konami, 4 SCC, 5 ASCII8, 6 ASCII16
//   offset       : plain-ROM start address in 4 KB units
//   rom_size     : image length in bytes
//   bus          : CPU and memory-arbiter signals (slave side)
module cart_rom_mapper #(
    parameter logic [24:0] BASE = 25'h0000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rom_loading,
    input  logic [2:0]           mapper,
    input  logic [3:0]           offset,
    input  logic [24:0]          rom_size,
    cart_rom_mapper_if.slave     bus
);

    typedef enum logic [1:0] {StIdle, StRead, StDone} state_e;

    state_e          state_q, state_d;
    logic            rd_q, wr_q;
    logic [2:0]      mapper_q;
    logic [3:0][7:0] bank_q, bank_d;
    logic [7:0]      cpu_dout_q, cpu_dout_d;
    logic            mem_rd_q, mem_rd_d;
    logic [24:0]     mem_addr_q, mem_addr_d;

    logic            rd_edge, wr_edge, force_banks;
    logic [15:0]     plain_base, plain_lin;
    logic [1:0]      page8;
    logic            in_mega, valid, hit;
    logic [24:0]     lin, mask, xlat_addr;

    // Smallest all-ones mask covering x (x = rom_size - 1).
    function automatic logic [24:0] smear(input logic [24:0] x);
        logic [24:0] m;
        m = x;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        return m;
    endfunction

    assign rd_edge     = bus.cs & bus.cpu_rd & ~rd_q;
    assign wr_edge     = bus.cs & bus.cpu_wr & ~wr_q;
    assign force_banks = rom_loading | (mapper != mapper_q);

    // Bank registers. A mapper change (including the first cycle after reset, since
    // mapper_q resets to 0) reloads the defaults for the new mapper.
    always_comb begin
        bank_d = bank_q;
        if (force_banks) begin
            if (mapper == 3'd5 || mapper == 3'd6) begin
                bank_d = {8'd0, 8'd0, 8'd0, 8'd0};
            end else begin
                bank_d = {8'd3, 8'd2, 8'd1, 8'd0};
            end
        end else if (wr_edge) begin
            case (mapper)
                3'd3: begin
                    case (bus.cpu_addr[15:13])
                        3'b011:  bank_d[1] = bus.cpu_din;
                        3'b100:  bank_d[2] = bus.cpu_din;
                        3'b101:  bank_d[3] = bus.cpu_din;
                        default: ;
                    endcase
                end
                3'd4: begin
                    case (bus.cpu_addr[15:11])
                        5'b01010: bank_d[0] = bus.cpu_din;
                        5'b01110: bank_d[1] = bus.cpu_din;
                        5'b10010: bank_d[2] = bus.cpu_din;
                        5'b10110: bank_d[3] = bus.cpu_din;
                        default:  ;
                    endcase
                end
                3'd5: begin
                    if (bus.cpu_addr[15:13] == 3'b011) begin
                        bank_d[bus.cpu_addr[12:11]] = bus.cpu_din;
                    end
                end
                3'd6: begin
                    case (bus.cpu_addr[15:11])
                        5'b01100: bank_d[0] = bus.cpu_din;
                        5'b01110: bank_d[1] = bus.cpu_din;
                        default:  ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Address translation from the current (pre-write) bank values.
    always_comb begin
        plain_base = {offset, 12'h000};
        plain_lin  = bus.cpu_addr - plain_base;
        page8      = bus.cpu_addr[14:13] ^ 2'b10;
        in_mega    = (bus.cpu_addr[15:14] == 2'b01) || (bus.cpu_addr[15:14] == 2'b10);
        lin        = '0;
        valid      = 1'b0;
        case (mapper)
            3'd1: begin
                lin   = {9'd0, plain_lin};
                valid = (bus.cpu_addr >= plain_base) && ({9'd0, plain_lin} < rom_size);
            end
            3'd3, 3'd4, 3'd5: begin
                lin   = {4'd0, bank_q[page8], bus.cpu_addr[12:0]};
                valid = in_mega;
            end
            3'd6: begin
                lin   = {3'd0, bank_q[{1'b0, bus.cpu_addr[15]}], bus.cpu_addr[13:0]};
                valid = in_mega;
            end
            default: ;
        endcase
        mask      = (rom_size == '0) ? '0 : smear(rom_size - 25'd1);
        hit       = valid & ~rom_loading;
        xlat_addr = BASE + (lin & mask);
    end

    always_comb begin
        state_d    = state_q;
        cpu_dout_d = cpu_dout_q;
        mem_rd_d   = mem_rd_q;
        mem_addr_d = mem_addr_q;
        unique case (state_q)
            StIdle: begin
                if (rd_edge) begin
                    if (hit) begin
                        state_d    = StRead;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = xlat_addr;
                    end else begin
                        state_d    = StDone;
                        cpu_dout_d = 8'hFF;
                    end
                end
            end
            StRead: begin
                if (rom_loading) begin
                    state_d    = StDone;
                    mem_rd_d   = 1'b0;
                    cpu_dout_d = 8'hFF;
                end else if (bus.mem_ack) begin
                    state_d    = StDone;
                    mem_rd_d   = 1'b0;
                    cpu_dout_d = bus.mem_din;
                end
            end
            StDone: begin
                if (!bus.cpu_rd || !bus.cs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            mapper_q   <= 3'd0;
            bank_q     <= {8'd3, 8'd2, 8'd1, 8'd0};
            cpu_dout_q <= 8'hFF;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= bus.cpu_rd;
            wr_q       <= bus.cpu_wr;
            mapper_q   <= mapper;
            bank_q     <= bank_d;
            cpu_dout_q <= cpu_dout_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign bus.cpu_dout = cpu_dout_q;
    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.cpu_wait = bus.cs & bus.cpu_rd & (state_q != StDone);

endmodule

// File: tb/tb_cart_rom_mapper.sv
// Randomized bench for cart_rom_mapper against a behavioural model of banks and translation.
module tb_cart_rom_mapper;
    localparam logic [24:0] BASE = 25'h0100000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rom_loading;
    logic [2:0]  mapper;
    logic [3:0]  offset;
    logic [24:0] rom_size;

    cart_rom_mapper_if bus ();

    cart_rom_mapper #(.BASE(BASE)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rom_loading (rom_loading),
        .mapper      (mapper),
        .offset      (offset),
        .rom_size    (rom_size),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          bank [4];
    logic [7:0]  model_dout;
    logic [24:0] last_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset_banks();
        for (int i = 0; i < 4; i++) bank[i] = (mapper == 3'd5 || mapper == 3'd6) ? 0 : i;
    endtask

    task automatic model_write(input int a, input int d);
        case (mapper)
            3'd3: begin
                if (a >= 'h6000 && a < 'h8000) bank[1] = d;
                else if (a >= 'h8000 && a < 'hA000) bank[2] = d;
                else if (a >= 'hA000 && a < 'hC000) bank[3] = d;
            end
            3'd4: begin
                if (a >= 'h5000 && a < 'h5800) bank[0] = d;
                else if (a >= 'h7000 && a < 'h7800) bank[1] = d;
                else if (a >= 'h9000 && a < 'h9800) bank[2] = d;
                else if (a >= 'hB000 && a < 'hB800) bank[3] = d;
            end
            3'd5: if (a >= 'h6000 && a < 'h8000) bank[(a - 'h6000) / 'h800] = d;
            3'd6: begin
                if (a >= 'h6000 && a < 'h6800) bank[0] = d;
                else if (a >= 'h7000 && a < 'h7800) bank[1] = d;
            end
            default: ;
        endcase
    endtask

    task automatic model_xlat(input int a, output bit hit, output logic [24:0] addr);
        longint lin, mask, off;
        int n;
        hit = 0;
        lin = 0;
        off = longint'(offset) * 4096;
        case (mapper)
            3'd1: if (a >= off && (a - off) < rom_size) begin hit = 1; lin = a - off; end
            3'd3, 3'd4, 3'd5: if (a >= 'h4000 && a < 'hC000) begin
                hit = 1;
                lin = longint'(bank[(a - 'h4000) / 'h2000]) * 'h2000 + a % 'h2000;
            end
            3'd6: if (a >= 'h4000 && a < 'hC000) begin
                hit = 1;
                lin = longint'(bank[a >= 'h8000 ? 1 : 0]) * 'h4000 + a % 'h4000;
            end
            default: hit = 0;
        endcase
        if (rom_loading) hit = 0;
        n = 0;
        while ((longint'(1) << n) < longint'(rom_size)) n++;
        mask = (longint'(1) << n) - 1;
        addr = 25'((longint'(BASE) + (lin & mask)) % (longint'(1) << 25));
    endtask

    task automatic set_cfg(input logic [2:0] m, input logic [24:0] size, input logic [3:0] off);
        bit changed;
        changed  = (m != mapper);
        mapper   = m;
        rom_size = size;
        offset   = off;
        if (changed) model_reset_banks();
        tick();
        tick();
    endtask

    task automatic cpu_write(input int a, input int d);
        bus.cs       = 1'b1;
        bus.cpu_addr = 16'(a);
        bus.cpu_din  = 8'(d);
        bus.cpu_wr   = 1'b1;
        model_write(a, d);
        tick();
        bus.cpu_wr = 1'b0;
        bus.cs     = 1'b0;
        tick();
    endtask

    // Full read transaction; optionally a write edge in the same cycle as the read edge.
    task automatic cpu_read(input int a, input int delay, input logic [7:0] data,
                            input bit do_wr, input int wdata);
        bit          hit;
        logic [24:0] ea;
        model_xlat(a, hit, ea);
        bus.cs       = 1'b1;
        bus.cpu_addr = 16'(a);
        bus.cpu_rd   = 1'b1;
        if (do_wr) begin
            bus.cpu_wr  = 1'b1;
            bus.cpu_din = 8'(wdata);
            model_write(a, wdata);
        end
        #1;
        check_eq("wait_edge", bus.cpu_wait, 1);
        tick();
        bus.cpu_wr = 1'b0;
        last_addr  = bus.mem_addr;
        if (hit) begin
            check_eq("mem_rd", bus.mem_rd, 1);
            check_eq("mem_addr", bus.mem_addr, ea);
            check_eq("wait_read", bus.cpu_wait, 1);
            for (int i = 0; i < delay; i++) begin
                tick();
                check_eq("wait_hold", bus.cpu_wait, 1);
                check_eq("addr_hold", bus.mem_addr, ea);
            end
            bus.mem_ack = 1'b1;
            bus.mem_din = data;
            tick();
            bus.mem_ack = 1'b0;
            model_dout  = data;
            check_eq("dout", bus.cpu_dout, data);
            check_eq("wait_done", bus.cpu_wait, 0);
            check_eq("mem_rd_off", bus.mem_rd, 0);
        end else begin
            model_dout = 8'hFF;
            check_eq("miss_rd", bus.mem_rd, 0);
            check_eq("miss_dout", bus.cpu_dout, 8'hFF);
            check_eq("miss_wait", bus.cpu_wait, 0);
        end
        bus.cpu_rd = 1'b0;
        bus.cs     = 1'b0;
        tick();
    endtask

    function automatic int rand_wr_addr();
        int bases [10] = '{'h4000, 'h5000, 'h6000, 'h6800, 'h7000, 'h7800,
                           'h8000, 'h9000, 'hA000, 'hB000};
        return bases[$urandom_range(0, 9)] + $urandom_range(0, 'h7FF);
    endfunction

    function automatic int rand_rd_addr();
        if ($urandom_range(0, 3) != 0) return $urandom_range('h4000, 'hBFFF);
        return $urandom_range(0, 'hFFFF);
    endfunction

    initial begin
        reset_n      = 1'b0;
        rom_loading  = 1'b0;
        mapper       = 3'd0;
        offset       = 4'd0;
        rom_size     = 25'd0;
        bus.cs       = 1'b0;
        bus.cpu_addr = 16'h0;
        bus.cpu_din  = 8'h0;
        bus.cpu_rd   = 1'b0;
        bus.cpu_wr   = 1'b0;
        bus.mem_ack  = 1'b0;
        bus.mem_din  = 8'h0;
        model_dout   = 8'hFF;
        for (int i = 0; i < 4; i++) bank[i] = i;
        tick();
        check_eq("rst_dout", bus.cpu_dout, 8'hFF);
        check_eq("rst_wait", bus.cpu_wait, 0);
        check_eq("rst_mem_rd", bus.mem_rd, 0);
        check_eq("rst_mem_addr", bus.mem_addr, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Konami defaults and a bank write
        set_cfg(3'd3, 25'h20000, 4'd0);
        cpu_read('h8000, 0, 8'h5A, 0, 0);
        check_eq("tp_konami_def", last_addr, BASE + 25'h4000);
        cpu_write('h8000, 'h05);
        cpu_read('h8123, 2, 8'hC3, 0, 0);
        check_eq("tp_konami_bank", last_addr, BASE + 25'hA123);

        // ASCII16 mirroring of an oversized bank
        set_cfg(3'd6, 25'h20000, 4'd0);
        cpu_write('h7000, 'h09);
        cpu_read('h8010, 1, 8'h11, 0, 0);
        check_eq("tp_ascii16_mirror", last_addr, BASE + 25'h04010);

        // Plain ROM with offset; out-of-image read misses
        set_cfg(3'd1, 25'h4000, 4'd4);
        cpu_read('h4005, 0, 8'h22, 0, 0);
        check_eq("tp_plain", last_addr, BASE + 25'h5);
        cpu_read('h8000, 0, 8'h00, 0, 0);
        cpu_read('h3FFF, 0, 8'h00, 0, 0);

        // SCC: bank write and an ignored write
        set_cfg(3'd4, 25'h20000, 4'd0);
        cpu_write('h5000, 'h03);
        cpu_write('h6000, 'h07);
        cpu_read('h4000, 0, 8'h44, 0, 0);
        check_eq("tp_scc_b0", last_addr, BASE + 25'h6000);
        cpu_read('h6000, 0, 8'h45, 0, 0);
        check_eq("tp_scc_b1", last_addr, BASE + 25'h2000);

        // ASCII8 simultaneous read and write edge
        set_cfg(3'd5, 25'h20000, 4'd0);
        cpu_read('h6000, 0, 8'h33, 1, 'h02);
        check_eq("tp_rw_same_old", last_addr, BASE + 25'h0);
        cpu_read('h4000, 0, 8'h34, 0, 0);
        check_eq("tp_rw_same_new", last_addr, BASE + 25'h4000);

        // Konami: write during an in-flight read keeps mem_addr
        set_cfg(3'd3, 25'h20000, 4'd0);
        bus.cs       = 1'b1;
        bus.cpu_addr = 16'hA010;
        bus.cpu_rd   = 1'b1;
        tick();
        check_eq("wr_in_read_rd", bus.mem_rd, 1);
        bus.cpu_addr = 16'hA000;
        bus.cpu_din  = 8'h0F;
        bus.cpu_wr   = 1'b1;
        model_write('hA000, 'h0F);
        tick();
        bus.cpu_wr = 1'b0;
        check_eq("wr_in_read_addr", bus.mem_addr, BASE + 25'h6010);
        bus.mem_ack = 1'b1;
        bus.mem_din = 8'h66;
        tick();
        bus.mem_ack = 1'b0;
        check_eq("wr_in_read_dout", bus.cpu_dout, 8'h66);
        bus.cpu_rd = 1'b0;
        bus.cs     = 1'b0;
        tick();
        cpu_read('hA000, 0, 8'h67, 0, 0);
        check_eq("wr_in_read_bank", last_addr, BASE + 25'h1E000);

        // rom_loading aborts a pending read and resets the banks
        bus.cs       = 1'b1;
        bus.cpu_addr = 16'h8000;
        bus.cpu_rd   = 1'b1;
        tick();
        check_eq("abort_rd_pre", bus.mem_rd, 1);
        tick();
        rom_loading = 1'b1;
        tick();
        check_eq("abort_rd", bus.mem_rd, 0);
        check_eq("abort_dout", bus.cpu_dout, 8'hFF);
        check_eq("abort_wait", bus.cpu_wait, 0);
        bus.mem_ack = 1'b1;
        bus.mem_din = 8'h77;
        tick();
        bus.mem_ack = 1'b0;
        check_eq("abort_late_ack", bus.cpu_dout, 8'hFF);
        bus.cpu_rd = 1'b0;
        bus.cs     = 1'b0;
        model_reset_banks();
        tick();
        rom_loading = 1'b0;
        tick();
        cpu_read('hA000, 0, 8'h78, 0, 0);
        check_eq("abort_bank_reset", last_addr, BASE + 25'h6000);

        // Reset in the middle of a read
        bus.cs       = 1'b1;
        bus.cpu_addr = 16'h6000;
        bus.cpu_rd   = 1'b1;
        tick();
        check_eq("rst_mid_pre", bus.mem_rd, 1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_rd", bus.mem_rd, 0);
        check_eq("rst_mid_dout", bus.cpu_dout, 8'hFF);
        check_eq("rst_mid_addr", bus.mem_addr, 0);
        bus.cpu_rd = 1'b0;
        bus.cs     = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        model_reset_banks();
        model_dout = 8'hFF;

        // Random traffic
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 5) begin
                logic [2:0]  m;
                logic [24:0] sz;
                int          sel;
                int          maps [7] = '{1, 3, 4, 5, 6, 0, 2};
                m   = 3'(maps[$urandom_range(0, ($urandom_range(0, 4) == 0) ? 6 : 4)]);
                sel = $urandom_range(0, 4);
                case (sel)
                    0:       sz = 25'h8000;
                    1:       sz = 25'h20000;
                    2:       sz = 25'h10000;
                    3:       sz = 25'($urandom_range('h2000, 'h30000));
                    default: sz = 25'($urandom_range(1, 'h1FFFFFF));
                endcase
                set_cfg(m, sz, 4'(4 * $urandom_range(0, 2)));
            end else if (r < 40) begin
                cpu_write(rand_wr_addr(), $urandom_range(0, 255));
            end else if (r < 48) begin
                cpu_read(rand_wr_addr(), $urandom_range(0, 3), 8'($urandom_range(0, 255)),
                         1, $urandom_range(0, 255));
            end else if (r < 53) begin
                bus.mem_ack = 1'b1;
                bus.mem_din = 8'($urandom_range(0, 255));
                tick();
                bus.mem_ack = 1'b0;
                check_eq("stray_ack", bus.cpu_dout, model_dout);
                check_eq("stray_rd", bus.mem_rd, 0);
            end else begin
                cpu_read(rand_rd_addr(), $urandom_range(0, 3), 8'($urandom_range(0, 255)), 0, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
